// File: rtl/dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_miss_ctrl
// Purpose  : Miss handler for the two-way D-cache. On a miss it optionally
//            drains the dirty victim line to memory, fetches the new line,
//            and writes it into the data array. The pipeline is stalled for
//            the whole sequence.
// Ports    : clk/rst            - clock, synchronous active-high reset
//            miss_req/miss_addr - miss request and address (sampled in IDLE)
//            victim_*           - way, dirty flag and tag of the LRU victim
//            stall_req          - pipeline stall
//            write_back/refresh - data-array read of victim / write of new line
//            refill_way/_index  - way and set being replaced
//            cacheline_old/new  - victim data in, fetched line out
//            wr_*               - write-back bus request/response
//            rd_*               - refill bus request/response
//            done               - one-cycle completion pulse to the tag stage
// Revision : 1.0 - initial release
// ============================================================================
module dcache_miss_ctrl #(
  parameter int LINE_W = 64,
  parameter int TAG_W  = 55,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [63:0]       miss_addr,
  input  logic              victim_way,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  output logic              stall_req,
  output logic              write_back,
  output logic              refresh,
  output logic              refill_way,
  output logic [IDX_W-1:0]  refill_index,
  input  logic [LINE_W-1:0] cacheline_old,
  output logic [LINE_W-1:0] cacheline_new,
  output logic              wr_req,
  output logic [63:0]       wr_addr,
  output logic [LINE_W-1:0] wr_data,
  input  logic              wr_ready,
  input  logic              wr_done,
  output logic              rd_req,
  output logic [63:0]       rd_addr,
  input  logic              rd_ready,
  input  logic              rd_valid,
  input  logic [LINE_W-1:0] rd_data,
  output logic              done
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WB_RD   = 4'd1;
  localparam logic [3:0] S_WB_CAP  = 4'd2;
  localparam logic [3:0] S_WB_REQ  = 4'd3;
  localparam logic [3:0] S_WB_WAIT = 4'd4;
  localparam logic [3:0] S_RD_REQ  = 4'd5;
  localparam logic [3:0] S_RD_WAIT = 4'd6;
  localparam logic [3:0] S_REFILL  = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic [63:3]       r_line_addr;   // line-aligned miss address
  logic              r_way;
  logic [TAG_W-1:0]  r_tag;
  logic [LINE_W-1:0] r_wr_data;
  logic [LINE_W-1:0] r_line_new;
  logic              w_accept;

  // Byte offset within the line is irrelevant to a whole-line refill.
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = &{1'b0, miss_addr[2:0]};

  assign w_accept = (r_state == S_IDLE) && miss_req;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (miss_req) w_next = victim_dirty ? S_WB_RD : S_RD_REQ;
      S_WB_RD:   w_next = S_WB_CAP;
      S_WB_CAP:  w_next = S_WB_REQ;
      S_WB_REQ:  if (wr_ready) w_next = S_WB_WAIT;
      // Read is only issued once the write-back is acknowledged, so a refill
      // of the same line can never overtake the victim data.
      S_WB_WAIT: if (wr_done) w_next = S_RD_REQ;
      S_RD_REQ:  if (rd_ready) w_next = S_RD_WAIT;
      S_RD_WAIT: if (rd_valid) w_next = S_REFILL;
      S_REFILL:  w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_line_addr <= '0;
      r_way       <= 1'b0;
      r_tag       <= '0;
      r_wr_data   <= '0;
      r_line_new  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_line_addr <= miss_addr[63:3];
        r_way       <= victim_way;
        r_tag       <= victim_tag;
      end
      // Array read data arrives one cycle after write_back.
      if (r_state == S_WB_CAP) r_wr_data <= cacheline_old;
      if ((r_state == S_RD_WAIT) && rd_valid) r_line_new <= rd_data;
    end
  end

  // Only stall_req sees an input combinationally, so the pipeline freezes
  // in the same cycle the miss is detected.
  assign stall_req     = (r_state == S_IDLE) ? miss_req : 1'b1;
  assign write_back    = (r_state == S_WB_RD);
  assign refresh       = (r_state == S_REFILL);
  assign wr_req        = (r_state == S_WB_REQ);
  assign rd_req        = (r_state == S_RD_REQ);
  assign done          = (r_state == S_DONE);
  assign refill_way    = r_way;
  assign refill_index  = r_line_addr[IDX_W+2:3];
  assign wr_addr       = {r_tag, r_line_addr[IDX_W+2:3], 3'b000};
  assign rd_addr       = {r_line_addr, 3'b000};
  assign wr_data       = r_wr_data;
  assign cacheline_new = r_line_new;

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_miss_ctrl
// Purpose  : Self-checking bench for dcache_miss_ctrl. A responder emulates
//            the bus bridge and data array; a scoreboard holds the expected
//            bus addresses, write-back data and refill contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_miss_ctrl;

  localparam int LINE_W = 64;
  localparam int TAG_W  = 55;
  localparam int IDX_W  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              miss_req;
  logic [63:0]       miss_addr;
  logic              victim_way;
  logic              victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic              stall_req;
  logic              write_back;
  logic              refresh;
  logic              refill_way;
  logic [IDX_W-1:0]  refill_index;
  logic [LINE_W-1:0] cacheline_old;
  logic [LINE_W-1:0] cacheline_new;
  logic              wr_req;
  logic [63:0]       wr_addr;
  logic [LINE_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_done;
  logic              rd_req;
  logic [63:0]       rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [LINE_W-1:0] rd_data;
  logic              done;

  dcache_miss_ctrl #(.LINE_W(LINE_W), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .victim_way(victim_way), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .stall_req(stall_req), .write_back(write_back), .refresh(refresh),
    .refill_way(refill_way), .refill_index(refill_index),
    .cacheline_old(cacheline_old), .cacheline_new(cacheline_new),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [63:0] addr; logic [63:0] data;} wr_t;
  typedef struct packed {logic way; logic [5:0] idx; logic [63:0] line;} rf_t;

  logic [63:0] exp_rd_q[$];
  wr_t         exp_wr_q[$];
  rf_t         exp_rf_q[$];
  logic [63:0] e_rd;
  wr_t         e_wr;
  rf_t         e_rf;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare bus handshakes and array writes as they occur.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_req && rd_ready) begin
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 64'(exp_rd_q.size()), 64'd1);
        else begin
          e_rd = exp_rd_q.pop_front();
          chk("rd_addr", rd_addr, e_rd);
        end
      end
      if (wr_req && wr_ready) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 64'(exp_wr_q.size()), 64'd1);
        else begin
          e_wr = exp_wr_q.pop_front();
          chk("wr_addr", wr_addr, e_wr.addr);
          chk("wr_data", wr_data, e_wr.data);
        end
      end
      if (refresh) begin
        if (exp_rf_q.size() == 0) chk("refill_unexpected", 64'(exp_rf_q.size()), 64'd1);
        else begin
          e_rf = exp_rf_q.pop_front();
          chk("refill_way", 64'(refill_way), 64'(e_rf.way));
          chk("refill_index", 64'(refill_index), 64'(e_rf.idx));
          chk("cacheline_new", cacheline_new, e_rf.line);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_stall"}, 64'(stall_req), 64'd0);
    chk({pfx, "_wb"}, 64'(write_back), 64'd0);
    chk({pfx, "_refresh"}, 64'(refresh), 64'd0);
    chk({pfx, "_done"}, 64'(done), 64'd0);
    chk({pfx, "_wr_req"}, 64'(wr_req), 64'd0);
    chk({pfx, "_rd_req"}, 64'(rd_req), 64'd0);
    chk({pfx, "_way"}, 64'(refill_way), 64'd0);
    chk({pfx, "_idx"}, 64'(refill_index), 64'd0);
    chk({pfx, "_line_new"}, cacheline_new, 64'd0);
    chk({pfx, "_wr_data"}, wr_data, 64'd0);
    chk({pfx, "_wr_addr"}, wr_addr, 64'd0);
    chk({pfx, "_rd_addr"}, rd_addr, 64'd0);
  endtask

  // One miss sequence (or n back-to-back with miss_req held). rd_wait is the
  // number of RD_REQ cycles with rd_ready low; wr_lat is the distance from
  // the write accept cycle to wr_done. stray pulses rd_valid in RD_REQ and
  // wr_done in WB_REQ. abort asserts rst in the first RD_WAIT cycle.
  task automatic run_miss(input logic [63:0] addr, input logic way, input logic dirty,
                          input logic [TAG_W-1:0] tag, input logic [63:0] old_line,
                          input logic [63:0] new_line, input logic [63:0] exp_rd,
                          input logic [63:0] exp_wr, input logic [5:0] exp_idx,
                          input int rd_wait, input int wr_lat, input bit stray,
                          input bit hold, input int n, input bit abort);
    int c, start_c, rd_cycles, rd_acc_c, wr_acc_c, wr_cycles, wb_cnt, stall_cnt;
    int misses_done, refresh_c, exp_done;
    bit prev_wb, wr_done_seen, order_bad, unstable, aborted;
    logic [63:0] rd_addr0, wr_addr0, wr_data0;
    exp_done = 4 + rd_wait + (dirty ? 3 + wr_lat : 0);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(exp_rd);
      if (dirty) exp_wr_q.push_back('{addr: exp_wr, data: old_line});
      exp_rf_q.push_back('{way: way, idx: exp_idx, line: new_line});
    end
    tick();
    miss_req = 1'b1; miss_addr = addr; victim_way = way;
    victim_dirty = dirty; victim_tag = tag;
    c = 0; start_c = 0; rd_cycles = 0; rd_acc_c = -1; wr_acc_c = -1; wr_cycles = 0;
    wb_cnt = 0; stall_cnt = 0; misses_done = 0; refresh_c = -1;
    prev_wb = 0; wr_done_seen = 0; order_bad = 0; unstable = 0; aborted = 0;
    rd_addr0 = '0; wr_addr0 = '0; wr_data0 = '0;
    while (1) begin
      rd_ready = 0; rd_valid = 0; wr_ready = 0; wr_done = 0;
      rd_data = {$urandom, $urandom};
      cacheline_old = prev_wb ? old_line : {$urandom, $urandom};
      #1;
      stall_cnt += int'(stall_req);
      if (write_back) wb_cnt++;
      if (wr_req) begin
        if (wr_cycles == 0) begin wr_addr0 = wr_addr; wr_data0 = wr_data; end
        else if (wr_addr !== wr_addr0 || wr_data !== wr_data0) unstable = 1;
        wr_cycles++;
        wr_ready = 1; wr_acc_c = c;
        if (stray) wr_done = 1;
      end
      if (wr_acc_c >= 0 && c == wr_acc_c + wr_lat) begin wr_done = 1; wr_done_seen = 1; end
      if (rd_req) begin
        if (dirty && !wr_done_seen) order_bad = 1;
        if (rd_cycles == 0) rd_addr0 = rd_addr;
        else if (rd_addr !== rd_addr0) unstable = 1;
        rd_cycles++;
        if (stray && rd_cycles == 1) begin rd_valid = 1; rd_data = ~new_line; end
        if (rd_cycles > rd_wait) begin rd_ready = 1; rd_acc_c = c; end
      end
      if (rd_acc_c >= 0 && c == rd_acc_c + 1) begin
        if (abort) begin rst = 1; aborted = 1; end
        else begin rd_valid = 1; rd_data = new_line; end
      end
      if (refresh) refresh_c = c - start_c;
      if (done) begin
        chk("done_cycle", 64'(c - start_c), 64'(exp_done));
        chk("refresh_cycle", 64'(refresh_c), 64'(exp_done - 1));
        chk("stall_cycles", 64'(stall_cnt), 64'(exp_done + 1));
        chk("wb_pulses", 64'(wb_cnt), 64'(dirty));
        chk("rd_req_cycles", 64'(rd_cycles), 64'(rd_wait + 1));
        chk("rd_after_wr_done", 64'(order_bad), 64'd0);
        chk("req_stable", 64'(unstable), 64'd0);
        misses_done++;
        if (misses_done == n) miss_req = 0;
        start_c = c + 1; rd_cycles = 0; rd_acc_c = -1; wr_acc_c = -1; wr_cycles = 0;
        wb_cnt = 0; stall_cnt = 0; refresh_c = -1; wr_done_seen = 0;
        order_bad = 0; unstable = 0;
      end
      prev_wb = write_back;
      if (aborted || misses_done == n) break;
      if (c > 300) begin
        chk("timeout", 64'(misses_done), 64'(n));
        break;
      end
      tick();
      c++;
      if (!hold) miss_req = 0;
    end
    if (aborted) begin
      void'(exp_rf_q.pop_back());
      tick();
      rst = 0; rd_valid = 0;
      #1;
      check_all_zero("rst_mid");
    end else begin
      tick();
      chk("post_done", 64'(done), 64'd0);
      chk("post_stall", 64'(stall_req), 64'd0);
      tick();
      chk("post_no_new_req", 64'(rd_req | wr_req | write_back), 64'd0);
    end
  endtask

  initial begin
    rst = 1; miss_req = 0; miss_addr = '0; victim_way = 0; victim_dirty = 0;
    victim_tag = '0; cacheline_old = '0; wr_ready = 0; wr_done = 0;
    rd_ready = 0; rd_valid = 0; rd_data = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 0;
    tick();

    // Clean miss, zero-wait memory.
    run_miss(64'h0000_0000_8000_1238, 1'b1, 1'b0, '0, 64'h0,
             64'hDEAD_BEEF_0123_4567, 64'h0000_0000_8000_1238, 64'h0, 6'h07,
             0, 1, 1'b0, 1'b0, 1, 1'b0);
    // Dirty miss, zero-wait memory.
    run_miss(64'h0000_0000_8000_1238, 1'b0, 1'b1, 55'h40_0000, 64'h1111_2222_3333_4444,
             64'hCAFE_F00D_5555_AAAA, 64'h0000_0000_8000_1238, 64'h0000_0000_8000_0038, 6'h07,
             0, 1, 1'b0, 1'b0, 1, 1'b0);
    // Dirty miss with read backpressure and slow write response, stray pulses.
    run_miss(64'h0000_0000_8000_1238, 1'b1, 1'b1, 55'h40_0000, 64'h0F0F_0F0F_A5A5_5A5A,
             64'h7777_8888_9999_0000, 64'h0000_0000_8000_1238, 64'h0000_0000_8000_0038, 6'h07,
             5, 7, 1'b1, 1'b0, 1, 1'b0);
    // Spurious rd_valid, miss_req held through two back-to-back misses.
    run_miss(64'h1234_5678_9ABC_DEF5, 1'b1, 1'b0, '0, 64'h0,
             64'h0BAD_C0DE_1357_9BDF, 64'h1234_5678_9ABC_DEF0, 64'h0, 6'h1E,
             2, 1, 1'b1, 1'b1, 2, 1'b0);
    // Reset while waiting for read data, then a normal clean miss.
    run_miss(64'h0000_0000_0000_0FF8, 1'b1, 1'b0, '0, 64'h0,
             64'hFFFF_0000_FFFF_0000, 64'h0000_0000_0000_0FF8, 64'h0, 6'h3F,
             0, 1, 1'b0, 1'b0, 1, 1'b1);
    run_miss(64'h0000_0000_0000_0FF8, 1'b0, 1'b0, '0, 64'h0,
             64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0FF8, 64'h0, 6'h3F,
             0, 1, 1'b0, 1'b0, 1, 1'b0);

    chk("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
    chk("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
    chk("rf_queue_empty", 64'(exp_rf_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_miss_ctrl.md
# dcache_miss_ctrl

Miss-handling controller for the two-way data cache, sitting between the D-cache tag/hit stage and the `dcache_data` array, and on the other side facing the memory bus bridge. On a cached miss it optionally drains the dirty victim line, fetches the new line, and writes it into the data array. It holds the pipeline stalled until the refill completes.

## Interface

**Parameters**
- `LINE_W`, default 64: cache line width in bits (one 8-byte line).
- `TAG_W`, default 55: tag width, address bits [63:9].
- `IDX_W`, default 6: index width, address bits [8:3].

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `miss_req` in 1: cached access missed both ways; level, sampled in IDLE only.
- `miss_addr` in 64: address of the missing access.
- `victim_way` in 1: LRU way chosen for replacement.
- `victim_dirty` in 1: victim line is valid and dirty.
- `victim_tag` in TAG_W: tag of the victim line.
- `stall_req` out 1: pipeline stall request.
- `write_back` out 1: data-array read of the victim line.
- `refresh` out 1: data-array write of the new line.
- `refill_way` out 1: way being replaced (latched `victim_way`).
- `refill_index` out IDX_W: set being replaced.
- `cacheline_old` in LINE_W: victim data from the array, valid the cycle after `write_back`.
- `cacheline_new` out LINE_W: fetched line.
- `wr_req` out 1, `wr_addr` out 64, `wr_data` out LINE_W: write-back request; held until accepted.
- `wr_ready` in 1: write request accepted this cycle.
- `wr_done` in 1: write response.
- `rd_req` out 1, `rd_addr` out 64: refill read request; held until accepted.
- `rd_ready` in 1: read request accepted this cycle.
- `rd_valid` in 1, `rd_data` in LINE_W: read data beat.
- `done` out 1: one-cycle pulse; the tag stage updates tag, valid, clean and LRU.

## Operation

**States:** IDLE, WB_RD, WB_CAP, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, REFILL, DONE.

**IDLE**
- When `miss_req` is high, latch `miss_addr`, `victim_way`, `victim_dirty`, `victim_tag`.
- Go to WB_RD if dirty, else RD_REQ.

**Write-back path**
- WB_RD: `write_back`=1 for exactly one cycle, with `refill_index` driven. Go to WB_CAP.
- WB_CAP: latch `cacheline_old` into the wr_data register. Go to WB_REQ.
- WB_REQ: `wr_req`=1 with `wr_addr`={victim_tag, index, 3'b0}. On `wr_ready`, go to WB_WAIT.
- WB_WAIT: on `wr_done`, go to RD_REQ.

**Refill path**
- RD_REQ: `rd_req`=1 with `rd_addr`={miss_addr[63:3], 3'b0}. On `rd_ready`, go to RD_WAIT.
- RD_WAIT: on `rd_valid`, latch `rd_data` into `cacheline_new`. Go to REFILL.
- REFILL: `refresh`=1 for one cycle, with `refill_way` and `refill_index` valid. Go to DONE.
- DONE: `done`=1. Go to IDLE.

**Rules**
- `stall_req` = `miss_req` in IDLE, 1 in every other state.
- `miss_req` is ignored outside IDLE.
- `wr_req`/`rd_req` stay high, with address and data stable, until the matching ready is seen.
- `rd_valid` and `wr_done` are sampled only in RD_WAIT and WB_WAIT respectively; stray pulses in other states are ignored.
- The write-back is fully completed (`wr_done`) before the read is issued. This gives no read-after-write hazard on the same line.
- `cacheline_new` and `wr_data` keep their last value after use.

## Timing

- **Reset:** state=IDLE; all outputs are 0, including `cacheline_new`, `wr_data`, `wr_addr`, `rd_addr`, `refill_way`, `refill_index`.
- **Reset mid-operation:** abort to IDLE next cycle and drop any outstanding bus transaction. The bus bridge is reset by the same `rst`.
- **Clean miss, zero-wait memory** (`rd_ready` in RD_REQ, `rd_valid` in the first RD_WAIT cycle): states IDLE→RD_REQ→RD_WAIT→REFILL→DONE→IDLE.
  - `refresh` in cycle 3 after `miss_req`; `done` in cycle 4.
  - `stall_req` is high for 5 cycles, counting the `miss_req` cycle.
- **Dirty miss:** add WB_RD, WB_CAP, WB_REQ, WB_WAIT. Minimum 4 extra cycles.
- **Back-to-back misses:** a new `miss_req` is accepted at the earliest in the IDLE cycle after DONE.
- All state transitions are registered. `stall_req` is the only output with a combinational path from an input (`miss_req`).

## Test plan

- **Clean miss:** `miss_addr`=0x8000_1238, dirty=0, way=1, memory zero-wait, `rd_data`=0xDEAD_BEEF_0123_4567.
  - Expect `rd_addr`=0x8000_1238 (already 8-byte aligned).
  - Expect `refresh` one cycle with `refill_way`=1, `refill_index`=0x07, `cacheline_new`=0xDEAD_BEEF_0123_4567.
  - Expect `done` at cycle 4 and 5 stall cycles.
- **Dirty miss:** `victim_tag`=0x40_0000 (all other bits 0), index 0x07, `cacheline_old`=0x1111_2222_3333_4444.
  - Expect `write_back` one cycle.
  - Expect `wr_addr`=0x8000_0038 and `wr_data`=0x1111_2222_3333_4444.
  - Expect `rd_req` only after `wr_done`.
- **Backpressure:** hold `rd_ready`=0 for 5 cycles, then `wr_done` 7 cycles after accept.
  - Expect requests and addresses stable throughout.
  - Expect no state advance until the handshake.
- **Spurious inputs:** `rd_valid` pulsed in RD_REQ, `miss_req` held high throughout.
  - Expect the stray `rd_valid` ignored.
  - Expect exactly one refill per IDLE entry.
- **Reset in RD_WAIT:** expect all outputs 0 next cycle, state IDLE, and a following clean miss to complete normally.
